// File: rtl/ring_slot_arbiter_pkg.sv
// Shared definitions for the ring slot arbiter: FSM state encoding and
// default parameter values used by the arbiter and its one-hot rotator.
package ring_slot_arbiter_pkg;

    // Two-state scheduler: SCAN walks the token, HOLD keeps a granted requester.
    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    localparam int DEF_N         = 6;
    localparam int DEF_MAX_HOLD  = 8;
    localparam int DEF_SKIP_IDLE = 0;

    // Hold counter width; the extra bit keeps MAX_HOLD=1 at a legal 1-bit width.
    function automatic int hold_cnt_w(input int max_hold);
        return $clog2(max_hold) + 1;
    endfunction

endpackage

// File: rtl/ring_slot_arbiter_onehot_rotator.sv
// One-hot token register. Resets to bit 0, rotates left by one on step and
// takes a parallel value on load (load has priority over step).
import ring_slot_arbiter_pkg::*;

module ring_slot_arbiter_onehot_rotator #(
    parameter int N = DEF_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_step,
    input  logic         i_load,
    input  logic [N-1:0] i_load_val,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    // Token register: reset to slot 0, otherwise load or rotate toward the MSB with wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= N'(1);
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_step) begin
            r_q <= {r_q[N-2:0], r_q[N-1]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/ring_slot_arbiter.sv
// Rotating-token time-slot arbiter. A one-hot token walks the slots; the
// requester under the token is granted until it releases, drops its request
// or reaches the tenure limit. Grant, busy and timeout are all registered.
import ring_slot_arbiter_pkg::*;

module ring_slot_arbiter #(
    parameter int N         = DEF_N,
    parameter int MAX_HOLD  = DEF_MAX_HOLD,
    parameter int SKIP_IDLE = DEF_SKIP_IDLE
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         En,
    input  logic [N-1:0] Req,
    input  logic [N-1:0] Done,
    output logic [N-1:0] Gnt,
    output logic [N-1:0] Slot,
    output logic         Busy,
    output logic         Timeout
);

    localparam int             CW        = hold_cnt_w(MAX_HOLD);
    localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;
    logic [CW-1:0] r_hold_cnt;
    logic [CW-1:0] w_hold_cnt_nxt;

    logic [N-1:0]  w_slot;
    logic          w_slot_step;
    logic          w_slot_load;
    logic [N-1:0]  w_slot_load_val;
    logic [N-1:0]  w_next_req;
    logic          w_hit;
    logic          w_release;

    // First requesting slot strictly after the token, searching upward with wrap.
    // The token slot itself is visited last, so a lone request there is still found.
    function automatic logic [N-1:0] find_next_req(input logic [N-1:0] slot,
                                                   input logic [N-1:0] req);
        logic [N-1:0] res;
        int           base;
        int           idx;
        logic         found;
        res   = '0;
        base  = 0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (slot[i]) base = i;
        end
        for (int k = 1; k <= N; k++) begin
            idx = (base + k) % N;
            if (!found && req[idx]) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    ring_slot_arbiter_onehot_rotator #(
        .N (N)
    ) u_rotator (
        .i_clk      (Clk),
        .i_rst      (Rst),
        .i_step     (w_slot_step),
        .i_load     (w_slot_load),
        .i_load_val (w_slot_load_val),
        .o_q        (w_slot)
    );

    assign w_next_req = find_next_req(w_slot, Req);
    assign w_hit      = |(Req & w_slot);
    // The holder gives up the resource on its own Done or when its request drops;
    // Done and Req bits of other requesters are masked by the grant.
    assign w_release  = (|(Done & r_gnt)) || !(|(Req & r_gnt));

    // Next-state and next-output logic for the SCAN/HOLD scheduler.
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_busy_nxt      = r_busy;
        w_timeout_nxt   = 1'b0;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_slot_step     = 1'b0;
        w_slot_load     = 1'b0;
        w_slot_load_val = w_slot;
        case (r_state)
            ST_SCAN: begin
                w_gnt_nxt  = '0;
                w_busy_nxt = 1'b0;
                if (En) begin
                    if (w_hit) begin
                        w_gnt_nxt      = w_slot;
                        w_busy_nxt     = 1'b1;
                        w_hold_cnt_nxt = '0;
                        w_state_nxt    = ST_HOLD;
                    end else if ((SKIP_IDLE != 0) && (|Req)) begin
                        // Jump straight to the next requester and grant it on the same edge.
                        w_slot_load     = 1'b1;
                        w_slot_load_val = w_next_req;
                        w_gnt_nxt       = w_next_req;
                        w_busy_nxt      = 1'b1;
                        w_hold_cnt_nxt  = '0;
                        w_state_nxt     = ST_HOLD;
                    end else begin
                        w_slot_step = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                // En is deliberately ignored here: an active grant is never preempted.
                if (w_release || (r_hold_cnt == HOLD_LAST)) begin
                    w_gnt_nxt      = '0;
                    w_busy_nxt     = 1'b0;
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = ST_SCAN;
                    w_slot_step    = 1'b1;
                    // A voluntary release on the last allowed cycle is not a timeout.
                    w_timeout_nxt  = !w_release;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_SCAN;
                w_gnt_nxt   = '0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears any grant in flight without a timeout.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= ST_SCAN;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_busy     <= w_busy_nxt;
            r_timeout  <= w_timeout_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    assign Gnt     = r_gnt;
    assign Slot    = w_slot;
    assign Busy    = r_busy;
    assign Timeout = r_timeout;

endmodule
